// File: rtl/noc_pkg.sv
// Shared NoC types used on both sides of the VC allocation handshake:
// output-port direction encoding and the input-VC lifecycle.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_dir_e;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_ROUTING,
    VC_AWAITING_VC,
    VC_ACTIVE
  } in_vc_state_e;

  // An input VC raises req toward an output allocator only in this state.
  function automatic logic vc_wants_alloc(in_vc_state_e s);
    return s == VC_AWAITING_VC;
  endfunction

endpackage

// File: rtl/vc_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic                enable,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant_onehot,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                valid
);

  int j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    valid        = 1'b0;
    j            = 0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        // ptr is always < N, so a single subtraction performs the wrap.
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (!valid && req[j]) begin
          valid           = 1'b1;
          grant_onehot[j] = 1'b1;
          grant_idx       = IDX_BITS'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vc_allocator.sv
// Per-output-port VC allocator: round-robin grant of the lowest free
// downstream VC, VC busy tracking until tail release, and per-VC credits.
module vc_allocator
  import noc_pkg::*;
#(
  parameter int NUM_REQ          = 10,
  parameter int VIRTUAL_CHANNELS = 2,
  parameter int DEPTH            = 4,
  parameter int VC_BITS          = (VIRTUAL_CHANNELS > 1) ? $clog2(VIRTUAL_CHANNELS) : 1,
  parameter int DEPTH_BITS       = $clog2(DEPTH),
  parameter int REQ_BITS         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQ-1:0]                         req,
  output logic [NUM_REQ-1:0]                         grant,
  output logic [VC_BITS-1:0]                         grant_vc,
  input  logic                                       release_valid,
  input  logic [VC_BITS-1:0]                         release_vc,
  input  logic                                       flit_sent,
  input  logic [VC_BITS-1:0]                         flit_sent_vc,
  input  logic [VIRTUAL_CHANNELS-1:0]                credit_in,
  output logic [VIRTUAL_CHANNELS-1:0]                vc_busy,
  output logic [VIRTUAL_CHANNELS*(DEPTH_BITS+1)-1:0] credits,
  output logic                                       error
);

  localparam int CW = DEPTH_BITS + 1;

  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [VC_BITS-1:0]          grant_vc_q, grant_vc_d;
  logic [VIRTUAL_CHANNELS-1:0] vc_busy_q, vc_busy_d;
  logic [CW-1:0]               credit_q [VIRTUAL_CHANNELS];
  logic [CW-1:0]               credit_d [VIRTUAL_CHANNELS];
  logic [REQ_BITS-1:0]         ptr_q, ptr_d;
  logic                        error_q, error_d;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [REQ_BITS-1:0] win_idx;
  logic                win_valid;
  logic [VC_BITS-1:0]  free_vc;
  logic                free_found;
  logic                inc, dec;

  always_comb begin
    free_vc    = '0;
    free_found = 1'b0;
    for (int i = VIRTUAL_CHANNELS - 1; i >= 0; i--) begin
      if (!vc_busy_q[i]) begin
        free_vc    = VC_BITS'(i);
        free_found = 1'b1;
      end
    end
  end

  // Masking with the registered grant keeps a winner from being granted
  // twice while its req is still high in the cycle it sees the grant.
  rr_arbiter #(
    .N        (NUM_REQ),
    .IDX_BITS (REQ_BITS)
  ) u_arb (
    .req          (req & ~grant_q),
    .enable       (free_found),
    .ptr          (ptr_q),
    .grant_onehot (win_onehot),
    .grant_idx    (win_idx),
    .valid        (win_valid)
  );

  always_comb begin
    grant_d    = '0;
    grant_vc_d = '0;
    vc_busy_d  = vc_busy_q;
    ptr_d      = ptr_q;
    error_d    = error_q;
    inc        = 1'b0;
    dec        = 1'b0;

    if (win_valid) begin
      grant_d    = win_onehot;
      grant_vc_d = free_vc;
      ptr_d      = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + REQ_BITS'(1);
    end

    if (release_valid) begin
      if (int'(release_vc) < VIRTUAL_CHANNELS && vc_busy_q[release_vc])
        vc_busy_d[release_vc] = 1'b0;
      else
        error_d = 1'b1;
    end

    // free_vc came from the pre-release mask, so it never collides with release_vc.
    if (win_valid) vc_busy_d[free_vc] = 1'b1;

    if (flit_sent && int'(flit_sent_vc) >= VIRTUAL_CHANNELS) error_d = 1'b1;

    for (int i = 0; i < VIRTUAL_CHANNELS; i++) begin
      credit_d[i] = credit_q[i];
      inc         = credit_in[i];
      dec         = flit_sent && (int'(flit_sent_vc) == i);
      if (inc && !dec) begin
        if (credit_q[i] == CW'(DEPTH)) error_d = 1'b1;
        else credit_d[i] = credit_q[i] + CW'(1);
      end else if (dec && !inc) begin
        if (credit_q[i] == '0) error_d = 1'b1;
        else credit_d[i] = credit_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= '0;
      grant_vc_q <= '0;
      vc_busy_q  <= '0;
      ptr_q      <= '0;
      error_q    <= 1'b0;
      for (int i = 0; i < VIRTUAL_CHANNELS; i++) credit_q[i] <= CW'(DEPTH);
    end else begin
      grant_q    <= grant_d;
      grant_vc_q <= grant_vc_d;
      vc_busy_q  <= vc_busy_d;
      ptr_q      <= ptr_d;
      error_q    <= error_d;
      for (int i = 0; i < VIRTUAL_CHANNELS; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign grant    = grant_q;
  assign grant_vc = grant_vc_q;
  assign vc_busy  = vc_busy_q;
  assign error    = error_q;

  for (genvar gi = 0; gi < VIRTUAL_CHANNELS; gi++) begin : g_credits
    assign credits[gi*CW +: CW] = credit_q[gi];
  end

endmodule

// File: tb/tb_vc_allocator.sv
// Self-checking bench for vc_allocator: directed scenarios plus a randomized
// run compared every cycle against a behavioural reference model.
module tb_vc_allocator;

  localparam int NREQ  = 4;
  localparam int VCS   = 2;
  localparam int DEPTH = 4;
  localparam int VB    = 1;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   grant;
  logic [VB-1:0]     grant_vc;
  logic              release_valid = 1'b0;
  logic [VB-1:0]     release_vc = '0;
  logic              flit_sent = 1'b0;
  logic [VB-1:0]     flit_sent_vc = '0;
  logic [VCS-1:0]    credit_in = '0;
  logic [VCS-1:0]    vc_busy;
  logic [VCS*CW-1:0] credits;
  logic              error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy [VCS];
  int m_cred [VCS];
  int m_ptr;
  int m_grant;
  int m_gvc;
  bit m_err;

  vc_allocator #(
    .NUM_REQ          (NREQ),
    .VIRTUAL_CHANNELS (VCS),
    .DEPTH            (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant         (grant),
    .grant_vc      (grant_vc),
    .release_valid (release_valid),
    .release_vc    (release_vc),
    .flit_sent     (flit_sent),
    .flit_sent_vc  (flit_sent_vc),
    .credit_in     (credit_in),
    .vc_busy       (vc_busy),
    .credits       (credits),
    .error         (error)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int v = 0; v < VCS; v++) begin
      m_busy[v] = 1'b0;
      m_cred[v] = DEPTH;
    end
    m_ptr = 0; m_grant = -1; m_gvc = 0; m_err = 1'b0;
  endfunction

  function automatic void model_step();
    int win, vc, idx;
    bit up, down;
    win = -1; vc = -1;
    for (int v = VCS - 1; v >= 0; v--) if (!m_busy[v]) vc = v;
    if (vc >= 0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && req[idx] && m_grant != idx) win = idx;
      end
    end
    if (release_valid) begin
      if (int'(release_vc) < VCS && m_busy[release_vc]) m_busy[release_vc] = 1'b0;
      else m_err = 1'b1;
    end
    if (flit_sent && int'(flit_sent_vc) >= VCS) m_err = 1'b1;
    for (int v = 0; v < VCS; v++) begin
      up   = credit_in[v];
      down = flit_sent && int'(flit_sent_vc) == v;
      if (up && !down) begin
        if (m_cred[v] == DEPTH) m_err = 1'b1; else m_cred[v]++;
      end else if (down && !up) begin
        if (m_cred[v] == 0) m_err = 1'b1; else m_cred[v]--;
      end
    end
    if (win >= 0) begin
      m_busy[vc] = 1'b1;
      m_ptr = (win + 1) % NREQ;
      m_grant = win;
      m_gvc = vc;
    end else begin
      m_grant = -1;
      m_gvc = 0;
    end
  endfunction

  function automatic logic [NREQ-1:0] exp_grant();
    return (m_grant < 0) ? '0 : NREQ'(1 << m_grant);
  endfunction

  function automatic logic [VCS-1:0] exp_busy();
    logic [VCS-1:0] b;
    for (int v = 0; v < VCS; v++) b[v] = m_busy[v];
    return b;
  endfunction

  function automatic logic [VCS*CW-1:0] exp_credits();
    logic [VCS*CW-1:0] c;
    for (int v = 0; v < VCS; v++) c[v*CW +: CW] = CW'(m_cred[v]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0; release_valid = 1'b0; flit_sent = 1'b0; credit_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (grant !== '0 || grant_vc !== '0 || vc_busy !== '0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got grant=%b vc=%0d busy=%b err=%b exp 0/0/0/0", grant, grant_vc, vc_busy, error);
    end
    checks++;
    if (credits !== {3'd4, 3'd4}) begin
      errors++;
      $display("FAIL reset_credits got %h exp %h", credits, {3'd4, 3'd4});
    end
    $display("txn reset: grant=%b busy=%b credits=%h err=%b", grant, vc_busy, credits, error);
  endtask

  task automatic test_alloc();
    req = 4'b0110;
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_vc !== 1'b0) begin
      errors++;
      $display("FAIL alloc_first got grant=%b vc=%0d exp 0010/0", grant, grant_vc);
    end
    $display("txn alloc: grant=%b vc=%0d", grant, grant_vc);
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_vc !== 1'b1 || vc_busy !== 2'b11) begin
      errors++;
      $display("FAIL alloc_second got grant=%b vc=%0d busy=%b exp 0100/1/11", grant, grant_vc, vc_busy);
    end
    $display("txn alloc: grant=%b vc=%0d busy=%b", grant, grant_vc, vc_busy);
    req = '0;
  endtask

  task automatic test_blocked();
    req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (grant !== '0) begin
        errors++;
        $display("FAIL blocked_hold cycle %0d got grant=%b exp 0000", c, grant);
      end
    end
    release_valid = 1'b1; release_vc = 1'b0;
    tick();
    release_valid = 1'b0;
    checks++;
    if (grant !== '0 || vc_busy !== 2'b10) begin
      errors++;
      $display("FAIL blocked_release_cycle got grant=%b busy=%b exp 0000/10", grant, vc_busy);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_vc !== 1'b0 || vc_busy !== 2'b11) begin
      errors++;
      $display("FAIL blocked_after_release got grant=%b vc=%0d busy=%b exp 1000/0/11", grant, grant_vc, vc_busy);
    end
    $display("txn blocked: grant=%b vc=%0d busy=%b", grant, grant_vc, vc_busy);
    req = '0;
    release_valid = 1'b1; release_vc = 1'b0;
    tick();
    release_vc = 1'b1;
    tick();
    release_valid = 1'b0;
    checks++;
    if (vc_busy !== 2'b00 || error !== 1'b0) begin
      errors++;
      $display("FAIL blocked_cleanup got busy=%b err=%b exp 00/0", vc_busy, error);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] expg;
    mask = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      req = mask;
      release_valid = (k > 0);
      release_vc = VB'(m_gvc);
      tick();
      expg = NREQ'(1 << k);
      checks++;
      if (grant !== expg || grant_vc !== VB'(k % 2)) begin
        errors++;
        $display("FAIL fairness_order step %0d got grant=%b vc=%0d exp %b/%0d", k, grant, grant_vc, expg, k % 2);
      end
      $display("txn fairness: step %0d grant=%b vc=%0d", k, grant, grant_vc);
      mask = mask & ~expg;
    end
    req = '0;
    release_valid = 1'b1; release_vc = VB'(m_gvc);
    tick();
    release_valid = 1'b0;
    checks++;
    if (vc_busy !== 2'b00) begin
      errors++;
      $display("FAIL fairness_cleanup got busy=%b exp 00", vc_busy);
    end
  endtask

  task automatic test_credits();
    flit_sent = 1'b1; flit_sent_vc = 1'b1;
    repeat (4) tick();
    checks++;
    if (credits[5:3] !== 3'd0 || credits[2:0] !== 3'd4 || error !== 1'b0) begin
      errors++;
      $display("FAIL credits_drain got vc1=%0d vc0=%0d err=%b exp 0/4/0", credits[5:3], credits[2:0], error);
    end
    tick();
    checks++;
    if (credits[5:3] !== 3'd0 || error !== 1'b1) begin
      errors++;
      $display("FAIL credits_underflow got vc1=%0d err=%b exp 0/1", credits[5:3], error);
    end
    credit_in = 2'b10;
    tick();
    checks++;
    if (credits[5:3] !== 3'd0) begin
      errors++;
      $display("FAIL credits_cancel got vc1=%0d exp 0", credits[5:3]);
    end
    flit_sent = 1'b0;
    tick();
    credit_in = '0;
    checks++;
    if (credits[5:3] !== 3'd1) begin
      errors++;
      $display("FAIL credits_return got vc1=%0d exp 1", credits[5:3]);
    end
    $display("txn credits: vc1=%0d vc0=%0d err=%b", credits[5:3], credits[2:0], error);
  endtask

  task automatic test_bad_release();
    apply_reset();
    release_valid = 1'b1; release_vc = 1'b1;
    tick();
    release_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || vc_busy !== 2'b00) begin
      errors++;
      $display("FAIL bad_release got err=%b busy=%b exp 1/00", error, vc_busy);
    end
    req = 4'b0011;
    tick();
    tick();
    req = '0;
    checks++;
    if (vc_busy !== 2'b11) begin
      errors++;
      $display("FAIL prefill_busy got busy=%b exp 11", vc_busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (vc_busy !== 2'b00 || credits !== {3'd4, 3'd4} || error !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b credits=%h err=%b grant=%b exp 00/%h/0/0000",
               vc_busy, credits, error, grant, {3'd4, 3'd4});
    end
    $display("txn async_reset: busy=%b credits=%h err=%b", vc_busy, credits, error);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    int pick;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      req = NREQ'($urandom_range(0, 15));
      release_valid = ($urandom_range(0, 3) == 0);
      pick = -1;
      for (int v = 0; v < VCS; v++) if (m_busy[v] && $urandom_range(0, 1) == 0) pick = v;
      if (pick < 0) for (int v = 0; v < VCS; v++) if (m_busy[v]) pick = v;
      if (pick < 0 || $urandom_range(0, 31) == 0) pick = $urandom_range(0, VCS - 1);
      release_vc = VB'(pick);
      for (int v = 0; v < VCS; v++)
        credit_in[v] = ($urandom_range(0, 2) == 0) && (m_cred[v] < DEPTH || $urandom_range(0, 31) == 0);
      flit_sent_vc = VB'($urandom_range(0, VCS - 1));
      flit_sent = ($urandom_range(0, 1) == 1) && (m_cred[flit_sent_vc] > 0 || $urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (grant !== exp_grant() || (grant !== '0 && grant_vc !== VB'(m_gvc)) || vc_busy !== exp_busy()
          || credits !== exp_credits() || error !== m_err) begin
        errors++;
        bad++;
        $display("FAIL random cycle %0d got g=%b vc=%0d busy=%b cr=%h err=%b exp g=%b vc=%0d busy=%b cr=%h err=%b",
                 c, grant, grant_vc, vc_busy, credits, error,
                 exp_grant(), m_gvc, exp_busy(), exp_credits(), m_err);
      end
    end
    req = '0; release_valid = 1'b0; flit_sent = 1'b0; credit_in = '0;
    $display("txn random: 300 cycles, %0d mismatched cycles", bad);
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_blocked();
    test_fairness();
    test_credits();
    test_bad_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
